// File: rtl/regfile_port_controller.sv
// rtl/regfile_port_controller.sv - register-file write port owner with post-reset clear and debug port arbitration
module regfile_port_controller #(
  parameter int NUM_REGS     = 32,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REG_W_En_W,
  input  logic [ADDR_W-1:0] RD_W,
  input  logic [DATA_W-1:0] Result_W,
  input  logic              DBG_Req,
  input  logic              DBG_Write,
  input  logic [ADDR_W-1:0] DBG_Addr,
  input  logic [DATA_W-1:0] DBG_W_Data,
  output logic              DBG_Ack,
  output logic [DATA_W-1:0] DBG_R_Data,
  output logic              RF_W_En,
  output logic [ADDR_W-1:0] RF_W_Addr,
  output logic [DATA_W-1:0] RF_W_Data,
  output logic [ADDR_W-1:0] RF_Dbg_R_Addr,
  input  logic [DATA_W-1:0] RF_Dbg_R_Data,
  output logic              Init_Busy,
  output logic              Stall_Req
);

  localparam int WAIT_W = 4;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
  localparam logic [WAIT_W-1:0] STARVE    = WAIT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_IDLE     = 2'd1,
    ST_DBG_PEND = 2'd2,
    ST_DBG_ACK  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0]   dbg_r_data_q, dbg_r_data_d;
  logic                stall_q, stall_d;
  logic                init_busy_q, init_busy_d;
  logic                cap_write_q, cap_write_d;
  logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0]   cap_data_q, cap_data_d;

  // State and capture registers; reset aborts any operation and restarts the clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_INIT;
      clr_cnt_q    <= ADDR_W'(1);
      wait_cnt_q   <= '0;
      dbg_ack_q    <= 1'b0;
      dbg_r_data_q <= '0;
      stall_q      <= 1'b0;
      init_busy_q  <= 1'b1;
      cap_write_q  <= 1'b0;
      cap_addr_q   <= '0;
      cap_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      dbg_ack_q    <= dbg_ack_d;
      dbg_r_data_q <= dbg_r_data_d;
      stall_q      <= stall_d;
      init_busy_q  <= init_busy_d;
      cap_write_q  <= cap_write_d;
      cap_addr_q   <= cap_addr_d;
      cap_data_q   <= cap_data_d;
    end
  end

  // Next-state logic: clear sequencing, debug capture, starvation tracking and ack.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    dbg_r_data_d = dbg_r_data_q;
    stall_d      = stall_q;
    cap_write_d  = cap_write_q;
    cap_addr_d   = cap_addr_q;
    cap_data_d   = cap_data_q;
    case (state_q)
      ST_INIT: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        stall_d   = 1'b0;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        stall_d = 1'b0;
        if (DBG_Req) begin
          cap_write_d = DBG_Write;
          cap_addr_d  = DBG_Addr;
          cap_data_d  = DBG_W_Data;
          wait_cnt_d  = '0;
          state_d     = ST_DBG_PEND;
        end
      end
      ST_DBG_PEND: begin
        if (REG_W_En_W) begin
          // Writeback owns the port this cycle; count how long debug has waited.
          if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
          if (wait_cnt_d >= STARVE) begin
            stall_d = 1'b1;
          end
        end else begin
          if (!cap_write_q) begin
            dbg_r_data_d = RF_Dbg_R_Data;
          end
          stall_d = 1'b0;
          state_d = ST_DBG_ACK;
        end
      end
      ST_DBG_ACK: begin
        stall_d = 1'b0;
        if (!DBG_Req) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
    dbg_ack_d   = (state_d == ST_DBG_ACK);
    init_busy_d = (state_d == ST_INIT);
  end

  // Write-port mux: clear beats writeback, writeback beats a pending debug write.
  always_comb begin
    RF_W_En   = 1'b0;
    RF_W_Addr = '0;
    RF_W_Data = '0;
    if (state_q == ST_INIT) begin
      RF_W_En   = 1'b1;
      RF_W_Addr = clr_cnt_q;
    end else if (REG_W_En_W) begin
      RF_W_En   = 1'b1;
      RF_W_Addr = RD_W;
      RF_W_Data = Result_W;
    end else if (state_q == ST_DBG_PEND && cap_write_q) begin
      RF_W_En   = (cap_addr_q != '0);
      RF_W_Addr = cap_addr_q;
      RF_W_Data = cap_data_q;
    end
  end

  assign RF_Dbg_R_Addr = cap_addr_q;
  assign DBG_Ack       = dbg_ack_q;
  assign DBG_R_Data    = dbg_r_data_q;
  assign Init_Busy     = init_busy_q;
  assign Stall_Req     = stall_q;

endmodule

// File: tb/tb_regfile_port_controller.sv
// tb/tb_regfile_port_controller.sv - directed self-checking bench for regfile_port_controller
module tb_regfile_port_controller;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        REG_W_En_W = 1'b0;
  logic [4:0]  RD_W = '0;
  logic [31:0] Result_W = '0;
  logic        DBG_Req = 1'b0;
  logic        DBG_Write = 1'b0;
  logic [4:0]  DBG_Addr = '0;
  logic [31:0] DBG_W_Data = '0;
  logic        DBG_Ack;
  logic [31:0] DBG_R_Data;
  logic        RF_W_En;
  logic [4:0]  RF_W_Addr;
  logic [31:0] RF_W_Data;
  logic [4:0]  RF_Dbg_R_Addr;
  logic [31:0] RF_Dbg_R_Data;
  logic        Init_Busy;
  logic        Stall_Req;

  int total = 0;
  int bad = 0;

  logic [31:0] rf [32] = '{default: 32'hBAD0BAD0};

  regfile_port_controller #(
    .NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(4)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REG_W_En_W(REG_W_En_W), .RD_W(RD_W), .Result_W(Result_W),
    .DBG_Req(DBG_Req), .DBG_Write(DBG_Write), .DBG_Addr(DBG_Addr),
    .DBG_W_Data(DBG_W_Data), .DBG_Ack(DBG_Ack), .DBG_R_Data(DBG_R_Data),
    .RF_W_En(RF_W_En), .RF_W_Addr(RF_W_Addr), .RF_W_Data(RF_W_Data),
    .RF_Dbg_R_Addr(RF_Dbg_R_Addr), .RF_Dbg_R_Data(RF_Dbg_R_Data),
    .Init_Busy(Init_Busy), .Stall_Req(Stall_Req)
  );

  always #5 CLK = ~CLK;

  // Register file without reset; x0 hardwired to zero on read.
  always @(posedge CLK) begin
    if (RF_W_En && RF_W_Addr != 5'd0) rf[RF_W_Addr] <= RF_W_Data;
  end
  assign RF_Dbg_R_Data = (RF_Dbg_R_Addr == 5'd0) ? 32'd0 : rf[RF_Dbg_R_Addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // Reset state with writeback hammering x5.
    REG_W_En_W = 1'b1; RD_W = 5'd5; Result_W = 32'hAAAA5555;
    #12;
    chk("rst_init_busy", {31'd0, Init_Busy}, 32'd1);
    chk("rst_ack", {31'd0, DBG_Ack}, 32'd0);
    chk("rst_stall", {31'd0, Stall_Req}, 32'd0);
    chk("rst_rdata", DBG_R_Data, 32'd0);
    RST_N = 1'b1;
    settle();

    // Clear sequence x1..x31, writeback dropped.
    for (int i = 1; i <= 31; i++) begin
      chk($sformatf("clr_addr_%0d", i), {27'd0, RF_W_Addr}, i);
      chk($sformatf("clr_data_%0d", i), RF_W_Data, 32'd0);
      chk($sformatf("clr_en_%0d", i), {31'd0, RF_W_En}, 32'd1);
      chk($sformatf("clr_busy_%0d", i), {31'd0, Init_Busy}, 32'd1);
      tick();
    end
    chk("init_done", {31'd0, Init_Busy}, 32'd0);
    REG_W_En_W = 1'b0;
    settle();
    chk("idle_port_off", {31'd0, RF_W_En}, 32'd0);

    // Writeback passthrough, same cycle.
    REG_W_En_W = 1'b1; RD_W = 5'd7; Result_W = 32'hDEADBEEF;
    settle();
    chk("wb_en", {31'd0, RF_W_En}, 32'd1);
    chk("wb_addr", {27'd0, RF_W_Addr}, 32'd7);
    chk("wb_data", RF_W_Data, 32'hDEADBEEF);
    tick();
    REG_W_En_W = 1'b0;

    // Debug write x3 with writeback idle.
    DBG_Req = 1'b1; DBG_Write = 1'b1; DBG_Addr = 5'd3; DBG_W_Data = 32'h12345678;
    tick();
    DBG_Addr = 5'd9; DBG_W_Data = 32'hFFFFFFFF;
    settle();
    chk("dw_en", {31'd0, RF_W_En}, 32'd1);
    chk("dw_addr", {27'd0, RF_W_Addr}, 32'd3);
    chk("dw_data", RF_W_Data, 32'h12345678);
    chk("dw_ack_c1", {31'd0, DBG_Ack}, 32'd0);
    tick();
    chk("dw_ack_c2", {31'd0, DBG_Ack}, 32'd1);
    chk("dw_port_off", {31'd0, RF_W_En}, 32'd0);
    tick();
    chk("dw_ack_hold", {31'd0, DBG_Ack}, 32'd1);
    DBG_Req = 1'b0;
    tick();
    chk("dw_ack_drop", {31'd0, DBG_Ack}, 32'd0);

    // Debug read x3 returns the debug-written value.
    DBG_Req = 1'b1; DBG_Write = 1'b0; DBG_Addr = 5'd3;
    tick();
    chk("dr_raddr", {27'd0, RF_Dbg_R_Addr}, 32'd3);
    chk("dr_no_write", {31'd0, RF_W_En}, 32'd0);
    tick();
    chk("dr_ack", {31'd0, DBG_Ack}, 32'd1);
    chk("dr_data", DBG_R_Data, 32'h12345678);
    DBG_Req = 1'b0;
    tick();

    // Read x5: clear won over the dropped writeback.
    DBG_Req = 1'b1; DBG_Write = 1'b0; DBG_Addr = 5'd5;
    tick(); tick();
    chk("x5_cleared", DBG_R_Data, 32'd0);
    DBG_Req = 1'b0;
    tick();

    // Starved debug read of x7 while writeback targets x9.
    DBG_Req = 1'b1; DBG_Write = 1'b0; DBG_Addr = 5'd7;
    REG_W_En_W = 1'b1; RD_W = 5'd9; Result_W = 32'h0BADF00D;
    tick();
    tick(); tick(); tick();
    chk("starve_3", {31'd0, Stall_Req}, 32'd0);
    tick();
    chk("starve_4", {31'd0, Stall_Req}, 32'd1);
    chk("starve_no_ack", {31'd0, DBG_Ack}, 32'd0);
    REG_W_En_W = 1'b0;
    settle();
    chk("starve_svc_en", {31'd0, RF_W_En}, 32'd0);
    tick();
    chk("starve_stall_clr", {31'd0, Stall_Req}, 32'd0);
    chk("starve_ack", {31'd0, DBG_Ack}, 32'd1);
    chk("starve_data", DBG_R_Data, 32'hDEADBEEF);
    DBG_Req = 1'b0;
    tick();

    // Debug write to x0: no port write, still acked, read data unchanged.
    DBG_Req = 1'b1; DBG_Write = 1'b1; DBG_Addr = 5'd0; DBG_W_Data = 32'h55555555;
    tick();
    chk("x0_no_en", {31'd0, RF_W_En}, 32'd0);
    tick();
    chk("x0_ack", {31'd0, DBG_Ack}, 32'd1);
    chk("x0_rdata_kept", DBG_R_Data, 32'hDEADBEEF);
    DBG_Req = 1'b0;
    tick();

    // Reset during a starved DBG_PEND.
    DBG_Req = 1'b1; DBG_Write = 1'b0; DBG_Addr = 5'd3;
    REG_W_En_W = 1'b1; RD_W = 5'd9;
    for (int i = 0; i < 6; i++) tick();
    chk("pre_rst_stall", {31'd0, Stall_Req}, 32'd1);
    RST_N = 1'b0;
    DBG_Req = 1'b0; REG_W_En_W = 1'b0;
    settle();
    chk("rst1_busy", {31'd0, Init_Busy}, 32'd1);
    chk("rst1_stall", {31'd0, Stall_Req}, 32'd0);
    chk("rst1_ack", {31'd0, DBG_Ack}, 32'd0);
    chk("rst1_addr", {27'd0, RF_W_Addr}, 32'd1);
    tick();
    RST_N = 1'b1;
    settle();
    for (int i = 1; i < 10; i++) tick();
    chk("mid_clr_addr", {27'd0, RF_W_Addr}, 32'd10);

    // Reset again mid-clear; the clear restarts at x1.
    RST_N = 1'b0;
    settle();
    chk("rst2_addr", {27'd0, RF_W_Addr}, 32'd1);
    chk("rst2_busy", {31'd0, Init_Busy}, 32'd1);
    tick();
    RST_N = 1'b1;
    settle();
    chk("rst2_restart", {27'd0, RF_W_Addr}, 32'd1);
    for (int i = 0; i < 34; i++) begin
      chk($sformatf("abort_no_ack_%0d", i), {31'd0, DBG_Ack}, 32'd0);
      tick();
    end
    chk("final_busy", {31'd0, Init_Busy}, 32'd0);
    chk("final_stall", {31'd0, Stall_Req}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
